objects_mux_layers: RTL and testbench

OBJECTS_MUX_LAYERS -- requirements
Module: objects_mux_layers

---
 rtl/objects_mux_pkg.sv | 13 +
 rtl/objects_collision_tracker.sv | 40 ++++
 rtl/objects_mux_layers.sv | 88 ++++++++
 tb/tb_objects_mux_layers.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/objects_mux_pkg.sv
// Shared defaults and the layer-index type for the object layer mixer.
package objects_mux_pkg;

   localparam int unsigned NUM_LAYERS_DEFAULT      = 4;
   localparam int unsigned RGB_WIDTH_DEFAULT       = 8;
   localparam int unsigned LAYER_IDX_WIDTH_DEFAULT = $clog2(NUM_LAYERS_DEFAULT + 1);

   localparam logic [RGB_WIDTH_DEFAULT-1:0] TRANSPARENT_COLOR_DEFAULT = 8'hFF;

   // Index of the winning layer; the value NUM_LAYERS_DEFAULT denotes background.
   typedef logic [LAYER_IDX_WIDTH_DEFAULT-1:0] layer_idx_t;

endpackage

// File: rtl/objects_collision_tracker.sv
// Per-frame collision tracker: accumulates layer-0 overlaps and reports them at frame start.
module objects_collision_tracker
   import objects_mux_pkg::*;
#(
   parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEFAULT
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  sof,
   input  logic [NUM_LAYERS-1:0] eff,
   output logic [NUM_LAYERS-1:0] frameHits,
   output logic                  collision
);

   logic [NUM_LAYERS-1:0] acc;
   logic [NUM_LAYERS-1:0] hit_c;

   // Pixel hit: layer 0 overlapping layer i; layer 0 never collides with itself.
   always_comb begin
      hit_c    = eff & {NUM_LAYERS{eff[0]}};
      hit_c[0] = 1'b0;
   end

   // Frame start publishes the finished frame and seeds the new one with this cycle's hits.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         acc       <= '0;
         frameHits <= '0;
         collision <= 1'b0;
      end else if (sof) begin
         frameHits <= acc;
         acc       <= hit_c;
         collision <= |acc;
      end else begin
         acc       <= acc | hit_c;
         collision <= 1'b0;
      end
   end

endmodule

// File: rtl/objects_mux_layers.sv
// Prioritised object-layer mixer with two-stage pixel pipeline and per-frame collision report.
module objects_mux_layers
   import objects_mux_pkg::*;
#(
   parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEFAULT,
   parameter int unsigned RGB_WIDTH  = RGB_WIDTH_DEFAULT,
   parameter logic [RGB_WIDTH-1:0] TRANSPARENT_COLOR = RGB_WIDTH'(TRANSPARENT_COLOR_DEFAULT),
   localparam int unsigned SEL_WIDTH = $clog2(NUM_LAYERS + 1)
) (
   input  logic                                 clk,
   input  logic                                 resetN,
   input  logic                                 startOfFrame,
   input  logic [NUM_LAYERS-1:0]                drawingRequest,
   input  logic [NUM_LAYERS-1:0][RGB_WIDTH-1:0] layerRGB,
   input  logic [NUM_LAYERS-1:0]                layerEnable,
   input  logic [RGB_WIDTH-1:0]                 backGroundRGB,
   output logic [RGB_WIDTH-1:0]                 RGBOut,
   output logic [SEL_WIDTH-1:0]                 layerSel,
   output logic [NUM_LAYERS-1:0]                frameHits,
   output logic                                 collision
);

   logic [NUM_LAYERS-1:0]                eff_c;
   logic [NUM_LAYERS-1:0]                eff_q;
   logic [NUM_LAYERS-1:0][RGB_WIDTH-1:0] rgb_q;
   logic [RGB_WIDTH-1:0]                 bg_q;
   logic                                 sof_q;
   logic [RGB_WIDTH-1:0]                 sel_rgb_c;
   logic [SEL_WIDTH-1:0]                 sel_idx_c;

   // Effective request: enabled, requesting and not the transparent colour.
   always_comb begin
      eff_c = '0;
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
         eff_c[i] = drawingRequest[i] & layerEnable[i] & (layerRGB[i] != TRANSPARENT_COLOR);
      end
   end

   // Stage 1: capture effective requests, colours and frame marker.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         eff_q <= '0;
         rgb_q <= '0;
         bg_q  <= '0;
         sof_q <= 1'b0;
      end else begin
         eff_q <= eff_c;
         rgb_q <= layerRGB;
         bg_q  <= backGroundRGB;
         sof_q <= startOfFrame;
      end
   end

   // Priority pick: scanning from the lowest priority up leaves the lowest active index.
   always_comb begin
      sel_rgb_c = bg_q;
      sel_idx_c = SEL_WIDTH'(NUM_LAYERS);
      for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
         if (eff_q[i]) begin
            sel_rgb_c = rgb_q[i];
            sel_idx_c = SEL_WIDTH'(i);
         end
      end
   end

   // Stage 2: register the selected pixel.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         RGBOut   <= '0;
         layerSel <= '0;
      end else begin
         RGBOut   <= sel_rgb_c;
         layerSel <= sel_idx_c;
      end
   end

   objects_collision_tracker #(
      .NUM_LAYERS (NUM_LAYERS)
   ) u_tracker (
      .clk       (clk),
      .resetN    (resetN),
      .sof       (sof_q),
      .eff       (eff_q),
      .frameHits (frameHits),
      .collision (collision)
   );

endmodule

// File: tb/tb_objects_mux_layers.sv
// Randomised and directed bench for objects_mux_layers against a frame-level reference model.
module tb_objects_mux_layers;
   import objects_mux_pkg::*;

   localparam int unsigned NL = NUM_LAYERS_DEFAULT;
   localparam int unsigned RW = RGB_WIDTH_DEFAULT;

   logic                  clk = 1'b0;
   logic                  resetN;
   logic                  startOfFrame;
   logic [NL-1:0]         drawingRequest;
   logic [NL-1:0][RW-1:0] layerRGB;
   logic [NL-1:0]         layerEnable;
   logic [RW-1:0]         backGroundRGB;
   logic [RW-1:0]         RGBOut;
   layer_idx_t            layerSel;
   logic [NL-1:0]         frameHits;
   logic                  collision;

   typedef struct {
      logic          valid;
      logic [RW-1:0] rgb;
      layer_idx_t    sel;
      logic [NL-1:0] fh;
      logic          coll;
   } exp_t;

   exp_t          e1, e2;
   logic [NL-1:0] acc_m;
   logic [NL-1:0] fh_m;
   int            n_tests = 0;
   int            n_fail  = 0;

   objects_mux_layers dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .drawingRequest (drawingRequest),
      .layerRGB       (layerRGB),
      .layerEnable    (layerEnable),
      .backGroundRGB  (backGroundRGB),
      .RGBOut         (RGBOut),
      .layerSel       (layerSel),
      .frameHits      (frameHits),
      .collision      (collision)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: list the layers that really draw, the first one wins; collisions are
   // collected per frame and published when the next frame marker arrives.
   task automatic push_expect();
      int            winners[$];
      exp_t          e;
      logic [NL-1:0] hit;
      for (int i = 0; i < int'(NL); i++) begin
         if (drawingRequest[i] && layerEnable[i] && layerRGB[i] != TRANSPARENT_COLOR_DEFAULT)
            winners.push_back(i);
      end
      e.valid = 1'b1;
      if (winners.size() == 0) begin
         e.rgb = backGroundRGB;
         e.sel = layer_idx_t'(NL);
      end else begin
         e.rgb = layerRGB[winners[0]];
         e.sel = layer_idx_t'(winners[0]);
      end
      hit = '0;
      if (winners.size() > 0 && winners[0] == 0) begin
         foreach (winners[k]) if (winners[k] != 0) hit[winners[k]] = 1'b1;
      end
      if (startOfFrame) begin
         fh_m   = acc_m;
         e.coll = (acc_m != '0);
         acc_m  = hit;
      end else begin
         acc_m  = acc_m | hit;
         e.coll = 1'b0;
      end
      e.fh = fh_m;
      e2 = e1;
      e1 = e;
   endtask

   task automatic check_outputs();
      if (e2.valid) begin
         check("rgb_out",    32'(RGBOut),    32'(e2.rgb));
         check("layer_sel",  32'(layerSel),  32'(e2.sel));
         check("frame_hits", 32'(frameHits), 32'(e2.fh));
         check("collision",  32'(collision), 32'(e2.coll));
      end
   endtask

   task automatic check_reset_zero(input string tag);
      check({tag, "_rgb"},  32'(RGBOut),    32'd0);
      check({tag, "_sel"},  32'(layerSel),  32'd0);
      check({tag, "_hits"}, 32'(frameHits), 32'd0);
      check({tag, "_coll"}, 32'(collision), 32'd0);
   endtask

   task automatic step(input logic sof, input logic [NL-1:0] req, input logic [NL-1:0] en,
                       input logic [NL-1:0][RW-1:0] rgb, input logic [RW-1:0] bg);
      @(negedge clk);
      check_outputs();
      startOfFrame   = sof;
      drawingRequest = req;
      layerEnable    = en;
      layerRGB       = rgb;
      backGroundRGB  = bg;
      push_expect();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      check_outputs();
      startOfFrame   = 1'b0;
      drawingRequest = '0;
      layerEnable    = '0;
      layerRGB       = '0;
      backGroundRGB  = '0;
      resetN         = 1'b0;
      #1;
      check_reset_zero("rst_async");
      acc_m    = '0;
      fh_m     = '0;
      e1.valid = 1'b0;
      e2.valid = 1'b0;
      @(negedge clk);
      check_reset_zero("rst_hold");
      resetN = 1'b1;
      push_expect();
   endtask

   function automatic logic [RW-1:0] rand_rgb();
      if ($urandom_range(0, 7) == 0) return TRANSPARENT_COLOR_DEFAULT;
      return RW'($urandom);
   endfunction

   logic [NL-1:0][RW-1:0] dir_rgb;
   logic [NL-1:0][RW-1:0] tr_rgb;
   logic [NL-1:0][RW-1:0] r_rgb;

   initial begin
      e1 = '{valid: 1'b0, rgb: '0, sel: '0, fh: '0, coll: 1'b0};
      e2 = e1;
      acc_m = '0;
      fh_m  = '0;
      resetN = 1'b0;
      startOfFrame = 1'b0;
      drawingRequest = '0;
      layerEnable = '0;
      layerRGB = '0;
      backGroundRGB = '0;
      dir_rgb = {8'h03, 8'h1C, 8'hE0, 8'h40};
      tr_rgb  = {8'h03, 8'h1C, 8'hE0, 8'hFF};

      apply_reset();

      // Single layer and priority/enable cases.
      step(1'b0, 4'b0100, 4'b1111, dir_rgb, 8'h2A);
      step(1'b0, 4'b1010, 4'b1111, dir_rgb, 8'h2A);
      step(1'b0, 4'b1010, 4'b1101, dir_rgb, 8'h2A);
      step(1'b0, 4'b0001, 4'b1111, tr_rgb,  8'h2A);
      step(1'b0, 4'b0000, 4'b1111, dir_rgb, 8'h2A);

      // Frame N with a 3-pixel overlap of layers 0 and 2, then a clean frame.
      step(1'b1, 4'b0000, 4'b1111, dir_rgb, 8'h2A);
      repeat (3) step(1'b0, 4'b0101, 4'b1111, dir_rgb, 8'h2A);
      repeat (2) step(1'b0, 4'b0010, 4'b1111, dir_rgb, 8'h2A);
      step(1'b1, 4'b0000, 4'b1111, dir_rgb, 8'h2A);
      repeat (2) step(1'b0, 4'b0001, 4'b1111, dir_rgb, 8'h2A);
      repeat (2) step(1'b0, 4'b0100, 4'b1111, dir_rgb, 8'h2A);
      step(1'b1, 4'b0000, 4'b1111, dir_rgb, 8'h2A);
      repeat (2) step(1'b0, 4'b0000, 4'b1111, dir_rgb, 8'h2A);

      // Overlap in the frame-start cycle itself is carried into the next frame.
      step(1'b1, 4'b0011, 4'b1111, dir_rgb, 8'h2A);
      repeat (3) step(1'b0, 4'b0000, 4'b1111, dir_rgb, 8'h2A);
      step(1'b1, 4'b0000, 4'b1111, dir_rgb, 8'h2A);
      step(1'b1, 4'b1001, 4'b1111, dir_rgb, 8'h2A);
      step(1'b1, 4'b0000, 4'b1111, dir_rgb, 8'h2A);
      repeat (2) step(1'b0, 4'b0000, 4'b1111, dir_rgb, 8'h2A);

      // Randomised traffic, including adjacent frame markers and disabled layers.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < int'(NL); i++) r_rgb[i] = rand_rgb();
         step(($urandom_range(0, 11) == 0),
              NL'($urandom),
              ($urandom_range(0, 3) == 0) ? NL'($urandom) : '1,
              r_rgb, RW'($urandom));
      end

      // Reset in the middle of a frame after an overlap.
      step(1'b1, 4'b0000, 4'b1111, dir_rgb, 8'h2A);
      repeat (2) step(1'b0, 4'b1001, 4'b1111, dir_rgb, 8'h2A);
      apply_reset();
      repeat (3) step(1'b0, 4'b0000, 4'b1111, dir_rgb, 8'h2A);
      step(1'b1, 4'b0000, 4'b1111, dir_rgb, 8'h2A);
      repeat (3) step(1'b0, 4'b0000, 4'b1111, dir_rgb, 8'h2A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
